// File: rtl/seven_segment_counter_multi_pkg.sv
// Shared constants for the multi-digit seven-segment counter.
// Glyphs are active-high, bit0 = a .. bit6 = g.
package seven_segment_counter_multi_pkg;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam int          PRE_WIDTH_DEF = 24;
   localparam int unsigned MAX_COUNT_DEF = 10_000_000;

   function automatic logic [3:0] bcd_sat(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/seven_segment_counter_multi_if.sv
// Control and display bundle between the pin mapping and the counter.
// The driver side holds the master modport, the counter the slave.
interface seven_segment_counter_multi_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    down;
   logic [7:0]              period_sel;
   logic                    clear;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] load_val;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [6:0]              segments;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    tick;
   logic                    wrap;

   modport master (
      output enable, down, period_sel, clear, load, load_val,
      input  bcd_out, segments, digit_sel, tick, wrap
   );

   modport slave (
      input  enable, down, period_sel, clear, load, load_val,
      output bcd_out, segments, digit_sel, tick, wrap
   );
endinterface

// File: rtl/seven_segment_counter_multi_seg7.sv
// BCD to seven-segment glyph decoder; out-of-range codes blank.
module seven_segment_counter_multi_seg7
   import seven_segment_counter_multi_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_counter_multi.sv
// N-digit BCD up/down counter with programmable prescaler
// and a multiplexed seven-segment display scanner.
module seven_segment_counter_multi
   import seven_segment_counter_multi_pkg::*;
#(
   parameter int          NUM_DIGITS   = 4,
   parameter int          PRE_WIDTH    = PRE_WIDTH_DEF,
   parameter int unsigned MAX_COUNT    = MAX_COUNT_DEF,
   parameter int          PERIOD_SHIFT = 10,
   parameter int          SCAN_DIV     = 1000
) (
   input  logic clk,
   input  logic reset,
   seven_segment_counter_multi_if.slave bus
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRE_WIDTH-1:0]    r_pre;
   logic                    r_tick;
   logic [PRE_WIDTH-1:0]    w_cmp;
   logic                    w_term;

   logic [4*NUM_DIGITS-1:0] r_dig;
   logic                    r_wrap;
   logic [4*NUM_DIGITS-1:0] w_nxt;
   logic [4*NUM_DIGITS-1:0] w_ld;
   logic [NUM_DIGITS-1:0]   w_lim;

   logic [CW-1:0]           r_scan;
   logic [IW-1:0]           r_idx;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic [6:0]              r_seg;
   logic                    w_scan_tc;
   logic [IW-1:0]           w_nidx;
   logic [3:0]              w_mux;
   logic [6:0]              w_seg;

   // Casting before the shift truncates high bits naturally.
   assign w_cmp = (bus.period_sel == 8'd0)
                ? PRE_WIDTH'(MAX_COUNT)
                : PRE_WIDTH'(bus.period_sel) << PERIOD_SHIFT;

   assign w_term = bus.enable && (r_pre == w_cmp);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else if (bus.clear) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_term;
         if (bus.enable)
            r_pre <= w_term ? '0 : r_pre + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      localparam logic [NUM_DIGITS-1:0] LOW =
         NUM_DIGITS'((64'd1 << g) - 64'd1);
      logic [3:0] w_d;
      logic [3:0] w_nd;
      logic       w_ci;

      assign w_d      = r_dig[4*g +: 4];
      assign w_lim[g] = bus.down ? (w_d == 4'd0) : (w_d == BCD_MAX);
      // A digit steps when every lower digit sits at its limit.
      assign w_ci     = w_term && (&(w_lim | ~LOW));
      assign w_ld[4*g +: 4] = bcd_sat(bus.load_val[4*g +: 4]);

      always_comb begin
         w_nd = w_d;
         if (w_ci) begin
            if (bus.down)
               w_nd = (w_d == 4'd0) ? BCD_MAX : w_d - 4'd1;
            else
               w_nd = (w_d == BCD_MAX) ? 4'd0 : w_d + 4'd1;
         end
      end

      assign w_nxt[4*g +: 4] = w_nd;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dig  <= '0;
         r_wrap <= 1'b0;
      end else if (bus.clear) begin
         r_dig  <= '0;
         r_wrap <= 1'b0;
      end else if (bus.load) begin
         r_dig  <= w_ld;
         r_wrap <= 1'b0;
      end else begin
         r_dig  <= w_nxt;
         r_wrap <= w_term && (&w_lim);
      end
   end

   assign w_scan_tc = (r_scan == CW'(SCAN_DIV - 1));

   always_comb begin
      w_nidx = r_idx;
      if (w_scan_tc)
         w_nidx = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
   end

   always_comb begin
      w_mux = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (IW'(i) == w_nidx)
            w_mux = r_dig[4*i +: 4];
   end

   seven_segment_counter_multi_seg7 u_seg7 (
      .i_digit (w_mux),
      .o_seg   (w_seg)
   );

   // Glyph and select register together so no ghost digit shows.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan <= '0;
         r_idx  <= '0;
         r_sel  <= NUM_DIGITS'(1);
         r_seg  <= SEG_0;
      end else begin
         r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
         r_idx  <= w_nidx;
         r_sel  <= NUM_DIGITS'(1) << w_nidx;
         r_seg  <= w_seg;
      end
   end

   assign bus.bcd_out   = r_dig;
   assign bus.segments  = r_seg;
   assign bus.digit_sel = r_sel;
   assign bus.tick      = r_tick;
   assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_seven_segment_counter_multi.sv
// Scoreboard bench: integer reference model predicts each cycle,
// a monitor pops and compares after every rising edge.
module tb_seven_segment_counter_multi;

   localparam int ND = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   seven_segment_counter_multi_if #(.NUM_DIGITS(ND)) bus ();

   seven_segment_counter_multi #(
      .NUM_DIGITS   (ND),
      .MAX_COUNT    (4),
      .PERIOD_SHIFT (2),
      .SCAN_DIV     (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] bcd;
      logic [6:0] seg;
      logic [1:0] sel;
      logic       tick;
      logic       wrap;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   int         m_pre, m_val, m_scan, m_idx;
   logic [6:0] m_seg;
   bit         m_tick, m_wrap;
   bit         r_dn;
   logic [7:0] r_ps;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   function automatic int sat(input logic [3:0] n);
      return (n > 4'd9) ? 9 : int'(n);
   endfunction

   function automatic int digit_of(input int v, input int i);
      return (i == 0) ? (v % 10) : ((v / 10) % 10);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Called at a falling edge: drive, predict, wait one cycle.
   task automatic step(input bit rst, input bit en, input bit dn,
                       input bit clr, input bit ld,
                       input logic [7:0] lv, input logic [7:0] ps);
      int   cmp;
      bit   term;
      exp_t e;
      reset          = rst;
      bus.enable     = en;
      bus.down       = dn;
      bus.clear      = clr;
      bus.load       = ld;
      bus.load_val   = lv;
      bus.period_sel = ps;
      if (rst) begin
         m_pre = 0; m_val = 0; m_scan = 0; m_idx = 0;
         m_tick = 0; m_wrap = 0; m_seg = glyph(0);
      end else begin
         cmp  = (ps == 8'd0) ? 4 : (int'(ps) * 4) % (1 << 24);
         term = en && (m_pre == cmp);
         if (m_scan == 2) begin
            m_scan = 0;
            m_idx  = (m_idx + 1) % ND;
         end else begin
            m_scan++;
         end
         m_seg = glyph(digit_of(m_val, m_idx));
         if (clr) begin
            m_pre = 0; m_val = 0; m_tick = 0; m_wrap = 0;
         end else begin
            m_tick = term;
            m_wrap = 0;
            if (en) m_pre = term ? 0 : (m_pre + 1) % (1 << 24);
            if (ld) begin
               m_val = sat(lv[7:4]) * 10 + sat(lv[3:0]);
            end else if (term) begin
               if (!dn) begin
                  m_wrap = (m_val == 99);
                  m_val  = (m_val + 1) % 100;
               end else begin
                  m_wrap = (m_val == 0);
                  m_val  = (m_val + 99) % 100;
               end
            end
         end
      end
      e.bcd  = {4'(m_val / 10), 4'(m_val % 10)};
      e.seg  = m_seg;
      e.sel  = 2'(1 << m_idx);
      e.tick = m_tick;
      e.wrap = m_wrap;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit dn, input logic [7:0] ps);
      for (int k = 0; k < n; k++)
         step(0, 1, dn, 0, 0, 8'h00, ps);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("bcd_out",   32'(bus.bcd_out),   32'(e.bcd));
            chk("segments",  32'(bus.segments),  32'(e.seg));
            chk("digit_sel", 32'(bus.digit_sel), 32'(e.sel));
            chk("tick",      32'(bus.tick),      32'(e.tick));
            chk("wrap",      32'(bus.wrap),      32'(e.wrap));
         end
      end
   end

   initial begin : driver
      reset = 1'b1;
      bus.enable = 0; bus.down = 0; bus.clear = 0;
      bus.load = 0; bus.load_val = '0; bus.period_sel = '0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 8'h00, 8'h00);
      step(1, 0, 0, 0, 0, 8'h00, 8'h00);
      run(60, 0, 8'h00);
      step(0, 1, 0, 0, 1, 8'h99, 8'h00);
      run(8, 0, 8'h00);
      step(0, 1, 1, 0, 1, 8'h00, 8'h00);
      run(8, 1, 8'h00);
      step(0, 1, 0, 0, 1, 8'hAF, 8'h00);
      run(3, 0, 8'h00);
      for (int k = 0; k < 10 && m_pre != 4; k++) run(1, 0, 8'h00);
      step(0, 1, 0, 0, 1, 8'h37, 8'h00);
      run(4, 0, 8'h00);
      for (int k = 0; k < 10 && m_pre != 3; k++) run(1, 0, 8'h00);
      step(0, 1, 0, 1, 0, 8'h00, 8'h00);
      run(12, 0, 8'h00);
      for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0, 8'h00, 8'h00);
      run(12, 0, 8'h01);
      step(1, 1, 0, 0, 0, 8'h00, 8'h01);
      run(7, 0, 8'h01);
      r_dn = 0;
      r_ps = 8'h00;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) < 2) r_dn = ~r_dn;
         if ($urandom_range(0, 99) < 1) r_ps = 8'($urandom_range(0, 3));
         step($urandom_range(0, 999) < 3,
              $urandom_range(0, 9) != 0,
              r_dn,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 3,
              8'($urandom),
              r_ps);
      end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_segment_counter_multi.md
Name: seven_segment_counter_multi

Overview:
Parametrised successor to the single-digit seconds counter. A programmable prescaler generates count ticks. An N-digit BCD counter counts up or down on those ticks, with pause, load and clear. The block drives one multiplexed seven-segment display, scanning one digit at a time, and sits directly behind the tt_um top-level pin mapping.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8)
PRE_WIDTH, 24, prescaler counter width
MAX_COUNT, 24'd10_000_000, default prescaler compare when period_sel == 0
PERIOD_SHIFT, 10, left shift applied to period_sel to form a non-default compare
SCAN_DIV, 1000, clk cycles each digit stays selected (>= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = prescaler runs; 0 = prescaler and counter hold (pause)
down  input  1  0 = count up, 1 = count down
period_sel  input  8  0 = use MAX_COUNT; otherwise compare = {period_sel, PERIOD_SHIFT zeros}, truncated/zero-extended to PRE_WIDTH
clear  input  1  synchronous clear of counter and prescaler
load  input  1  load load_val into the digits
load_val  input  4*NUM_DIGITS  BCD load value, digit 0 in the LSBs
bcd_out  output  4*NUM_DIGITS  current counter value, digit 0 in the LSBs
segments  output  7  segments of the selected digit, bit0 = a .. bit6 = g, active-high
digit_sel  output  NUM_DIGITS  one-hot, active-high digit enable
tick  output  1  one-cycle pulse when the prescaler expires
wrap  output  1  one-cycle pulse when the counter wraps

Behaviour:
- Reset values:
  - pre_cnt = 0; all digits = 0; bcd_out = 0
  - tick = 0; wrap = 0; scan counter = 0
  - digit_sel = 1 (digit 0 selected); segments = 7'b0111111 (glyph "0")
- Prescaler:
  - Counts only while enable = 1.
  - When pre_cnt == compare: pre_cnt goes to 0 and tick = 1 for the next cycle (registered). The tick period is therefore compare+1 cycles.
  - Otherwise pre_cnt increments.
  - If compare changes so that pre_cnt > compare, pre_cnt keeps counting and wraps at 2^PRE_WIDTH. No special handling.
- Counter priority, highest first: reset > clear > load > tick.
  - clear: all digits = 0, pre_cnt = 0, tick and wrap not asserted that cycle.
  - load: digit i = load_val[4i+3:4i], except any nibble > 9 loads as 9. pre_cnt is unaffected. A tick coinciding with load is dropped.
  - Tick, up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - Tick, down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
  - Wrap: all-9 to all-0 (up) or all-0 to all-9 (down). wrap pulses in the same cycle the digits update.
  - Digit updates occur on the cycle after the prescaler terminal count, aligned with tick.
- bcd_out is the digit registers directly, with zero latency from a digit update.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1 and runs independently of enable, clear and load.
  - At terminal count it advances the index to (index+1) mod NUM_DIGITS and rotates digit_sel left, wrapping.
  - segments is registered: seg7 decode of the digit at the next index. segments and digit_sel always change in the same cycle, so there are no ghost glyphs.
  - A digit value change appears on segments by the next scan step, or within 1 cycle if that digit is already selected.
- Decode:
  - 0..9 use the standard glyphs.
  - Internal values > 9 are unreachable; if one occurs, blank it (7'b0).
- Widths:
  - Digit arithmetic is 4-bit.
  - The compare is computed at PRE_WIDTH bits; the shifted period_sel is truncated if wider.

Decomposition:
- Shared package holds:
  - seg7 glyph constants SEG_0..SEG_9 and SEG_BLANK
  - BCD_MAX = 4'd9
  - default PRE_WIDTH and MAX_COUNT values
- Reuse the existing seg7 decoder as the one sub-module, instantiated once on the muxed digit.
- Per-digit carry/borrow logic is a generate loop inside this module; there is no separate module for it.

Test Plan:
Test parameters: NUM_DIGITS = 2, MAX_COUNT = 4, SCAN_DIV = 3.
- Reset, then enable = 1, period_sel = 0: tick every 5 cycles; bcd_out runs 0x00, 0x01, ... 0x09, 0x10 (carry). segments shows 7'b0111111 at reset.
- Load 0x99, up: next tick gives bcd_out 0x00 with wrap = 1 for exactly one cycle. Load 0x00, down = 1: next tick gives 0x99 and wrap = 1.
- load_val = 8'hAF: bcd_out = 0x99 (saturated). load and tick in the same cycle: load wins and no increment occurs.
- clear pulsed mid-count with pre_cnt = 3: bcd_out = 0, next tick arrives 5 cycles later. Hold enable = 0 for 20 cycles: bcd_out frozen, no tick, scan continues.
- Scan: digit_sel sequence 01, 10, 01 changing every 3 cycles. With bcd_out = 0x37, segments = SEG_7 while digit_sel = 01 and SEG_3 while digit_sel = 10.
- period_sel = 1, PERIOD_SHIFT = 2: compare = 4, so the tick period is 5 cycles. Reset asserted mid-scan: all outputs return to their reset values on the next edge.
